// File: rtl/writeback_rf_pkg.sv
// Shared widths and register-index type for the writeback stage, decode and hazard logic.
package writeback_rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/writeback_rf_regfile_2r1w.sv
// Integer register storage: one synchronous write port, two raw combinational read ports.
module regfile_2r1w
    import writeback_rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(NREGS)-1:0] raddr_a,
    input  logic [$clog2(NREGS)-1:0] raddr_b,
    output logic [XLEN-1:0]          rdata_a,
    output logic [XLEN-1:0]          rdata_b
);

    logic [XLEN-1:0] regs [NREGS];

    // The whole array clears asynchronously so reads return zero while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/writeback_rf.sv
// Writeback select, register-file commit, bypassed decode read ports and commit counter.
module writeback_rf
    import writeback_rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  reg_idx_t        rd_wb,
    input  logic            im_to_rf_wb,
    input  logic            load_wb,
    input  logic [XLEN-1:0] alu_data_wb,
    input  logic [XLEN-1:0] dm_data_wb,
    input  reg_idx_t        rs1_id,
    input  reg_idx_t        rs2_id,
    output logic [XLEN-1:0] rs1_data_id,
    output logic [XLEN-1:0] rs2_data_id,
    output logic [XLEN-1:0] wb_data,
    output reg_idx_t        wb_rd,
    output logic            wb_we,
    output logic [31:0]     wr_count
);

    logic [XLEN-1:0] raw_a;
    logic [XLEN-1:0] raw_b;
    logic [31:0]     wr_count_q;

    assign wb_data = load_wb ? dm_data_wb : alu_data_wb;
    assign wb_rd   = rd_wb;
    assign wb_we   = im_to_rf_wb && (rd_wb != REG_ZERO);

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_we),
        .waddr   (rd_wb[$clog2(NREGS)-1:0]),
        .wdata   (wb_data),
        .raddr_a (rs1_id[$clog2(NREGS)-1:0]),
        .raddr_b (rs2_id[$clog2(NREGS)-1:0]),
        .rdata_a (raw_a),
        .rdata_b (raw_b)
    );

    // x0 masking takes priority over the bypass, so a stray x0 write never leaks through.
    always_comb begin
        rs1_data_id = raw_a;
        if (rs1_id == REG_ZERO) begin
            rs1_data_id = '0;
        end else if (wb_we && (rs1_id == rd_wb)) begin
            rs1_data_id = wb_data;
        end
    end

    always_comb begin
        rs2_data_id = raw_b;
        if (rs2_id == REG_ZERO) begin
            rs2_data_id = '0;
        end else if (wb_we && (rs2_id == rd_wb)) begin
            rs2_data_id = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
        end else if (wb_we) begin
            wr_count_q <= wr_count_q + 32'd1;
        end
    end

    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_writeback_rf.sv
// Directed checks of writeback select, commit, bypass, x0 masking, reset and counter wrap.
module tb_writeback_rf;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_wb;
    logic        im_to_rf_wb;
    logic        load_wb;
    logic [31:0] alu_data_wb;
    logic [31:0] dm_data_wb;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [31:0] rs1_data_id;
    logic [31:0] rs2_data_id;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    writeback_rf dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_wb       (rd_wb),
        .im_to_rf_wb (im_to_rf_wb),
        .load_wb     (load_wb),
        .alu_data_wb (alu_data_wb),
        .dm_data_wb  (dm_data_wb),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_data_id (rs1_data_id),
        .rs2_data_id (rs2_data_id),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_we       (wb_we),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rd, input logic we, input logic ld,
                         input logic [31:0] alu, input logic [31:0] dm);
        rd_wb       = rd;
        im_to_rf_wb = we;
        load_wb     = ld;
        alu_data_wb = alu;
        dm_data_wb  = dm;
    endtask

    task automatic idle();
        drive(5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Advance through one rising edge and settle at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        rs1_id = 5'd5;
        rs2_id = 5'd0;
        idle();
        #1;
        chk("reset_rs1_x5", rs1_data_id, 32'h0);
        chk("reset_count", wr_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload x5, then reset mid-cycle with no clock edge in between.
        drive(5'd5, 1'b1, 1'b0, 32'h0000_1234, 32'h0);
        step();
        idle();
        #1;
        chk("preload_x5", rs1_data_id, 32'h0000_1234);
        chk("preload_count", wr_count, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_x5", rs1_data_id, 32'h0);
        chk("async_rst_count", wr_count, 32'h0);
        drive(5'd6, 1'b1, 1'b0, 32'd77, 32'h0);
        rs1_id = 5'd6;
        #1;
        chk("rst_bypass_wb_data", wb_data, 32'd77);
        step();
        idle();
        #1;
        chk("rst_no_commit_x6", rs1_data_id, 32'h0);
        chk("rst_no_count", wr_count, 32'h0);
        rst_n = 1'b1;

        // ALU commit with same-cycle bypass
        drive(5'd3, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
        rs1_id = 5'd3;
        #1;
        chk("alu_bypass_rs1", rs1_data_id, 32'hDEAD_BEEF);
        chk("alu_wb_we", {31'h0, wb_we}, 32'd1);
        chk("alu_wb_rd", {27'h0, wb_rd}, 32'd3);
        step();
        idle();
        #1;
        chk("alu_stored_rs1", rs1_data_id, 32'hDEAD_BEEF);
        chk("alu_count", wr_count, 32'd1);

        // Load select
        drive(5'd7, 1'b1, 1'b1, 32'h5555_5555, 32'h0000_00FF);
        #1;
        chk("load_wb_data", wb_data, 32'h0000_00FF);
        step();
        idle();
        rs2_id = 5'd7;
        #1;
        chk("load_stored_rs2", rs2_data_id, 32'h0000_00FF);
        chk("load_count", wr_count, 32'd2);

        // x0 protection
        drive(5'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
        rs1_id = 5'd0;
        rs2_id = 5'd0;
        #1;
        chk("x0_wb_we", {31'h0, wb_we}, 32'd0);
        chk("x0_wb_data", wb_data, 32'hFFFF_FFFF);
        chk("x0_rs1", rs1_data_id, 32'h0);
        chk("x0_rs2", rs2_data_id, 32'h0);
        step();
        idle();
        #1;
        chk("x0_after_rs1", rs1_data_id, 32'h0);
        chk("x0_count", wr_count, 32'd2);

        // Dual-port bypass on the same index
        drive(5'd9, 1'b1, 1'b0, 32'd1, 32'h0);
        step();
        drive(5'd9, 1'b0, 1'b0, 32'd2, 32'h0);
        rs1_id = 5'd9;
        rs2_id = 5'd9;
        #1;
        chk("no_we_no_bypass", rs1_data_id, 32'd1);
        im_to_rf_wb = 1'b1;
        #1;
        chk("dual_bypass_rs1", rs1_data_id, 32'd2);
        chk("dual_bypass_rs2", rs2_data_id, 32'd2);
        rs2_id = 5'd3;
        #1;
        chk("other_idx_stored", rs2_data_id, 32'hDEAD_BEEF);
        rs2_id = 5'd9;
        step();
        idle();
        #1;
        chk("dual_stored_rs1", rs1_data_id, 32'd2);
        chk("dual_stored_rs2", rs2_data_id, 32'd2);
        chk("dual_count", wr_count, 32'd4);

        // Back-to-back writes on consecutive edges
        for (int i = 0; i < 3; i++) begin
            drive(5'(10 + i), 1'b1, 1'b0, 32'(100 + i), 32'h0);
            step();
            #1;
            chk($sformatf("b2b_count_%0d", i), wr_count, 32'(5 + i));
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            rs1_id = 5'(10 + i);
            #1;
            chk($sformatf("b2b_data_x%0d", 10 + i), rs1_data_id, 32'(100 + i));
        end

        // Counter wrap from all-ones
        force dut.wr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count_q;
        #1;
        chk("wrap_preset", wr_count, 32'hFFFF_FFFF);
        drive(5'd13, 1'b1, 1'b0, 32'h0BAD_F00D, 32'h0);
        step();
        #1;
        chk("wrap_zero", wr_count, 32'h0);
        step();
        idle();
        #1;
        chk("wrap_plus_one", wr_count, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_rf.md
# writeback_rf

Writeback stage plus architectural register file: consumes the MEM/WB pipeline register outputs, selects the writeback value, commits it to a 32-entry integer register file, and serves the decode stage's two combinational read ports with same-cycle write-through bypass. Sits at the downstream end of the MEM/WB interface and the upstream end of the ID read path. Also exports the current writeback value to the hazard/forwarding unit and counts committed writes for debug.

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, register count; index width is $clog2(NREGS)

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- rd_wb  input  5  destination register index from MEM/WB
- im_to_rf_wb  input  1  register-file write enable from MEM/WB
- load_wb  input  1  1 selects dm_data_wb, 0 selects alu_data_wb
- alu_data_wb  input  XLEN  ALU/immediate result
- dm_data_wb  input  XLEN  data-memory load result
- rs1_id  input  5  read port A index
- rs2_id  input  5  read port B index
- rs1_data_id  output  XLEN  read port A data, combinational
- rs2_data_id  output  XLEN  read port B data, combinational
- wb_data  output  XLEN  selected writeback value, combinational, to forwarding unit
- wb_rd  output  5  equals rd_wb
- wb_we  output  1  effective write enable: im_to_rf_wb && rd_wb != 0
- wr_count  output  32  number of committed writes since reset

## Operation
- wb_data = load_wb ? dm_data_wb : alu_data_wb; no extension or masking here, the load path delivers a sized, extended word.
- Commit: on the rising edge with wb_we=1, regs[rd_wb] <= wb_data.
- x0: never written; a read of index 0 returns 0 regardless of bypass.
- Read port (each independently): if index==0 → 0; else if wb_we && index==rd_wb → wb_data (write-through bypass); else regs[index].
- Both ports may read the same index; both may hit the bypass in the same cycle.
- wr_count increments by 1 on each edge with wb_we=1 and wraps from 0xFFFF_FFFF to 0. Writes to x0 are not counted.
- Reset (rst_n=0, asynchronous): all regs cleared to 0 and wr_count cleared to 0 immediately, independent of clk. A write presented in the same cycle that reset deasserts is not committed on that edge unless rst_n is already high at the edge.
- Reset mid-stream: any in-flight MEM/WB values are ignored while rst_n=0; the combinational outputs still reflect the inputs, but reads return 0 from storage.

## Timing
- Write latency: 1 edge. Value visible in storage from the cycle after the edge; visible through the bypass in the same cycle it is presented.
- Read latency: 0 cycles (combinational).
- wb_data, wb_rd, wb_we: 0 cycles, combinational from inputs.
- Reset values: all regs 0; wr_count 0; rs1_data_id/rs2_data_id = 0 for any index not bypassed.
- No handshake. The stage commits every cycle; stalls and bubbles are expressed upstream by im_to_rf_wb=0.

## Structure
- Shared package: the XLEN and NREGS defaults, the REG_ZERO index constant, and a typedef for the register index (logic [4:0]), reused by the hazard unit and the decode stage.
- One natural sub-module: regfile_2r1w, holding the storage array, the asynchronous clear, and the two raw read ports. The top level adds the writeback mux, bypass, x0 masking, and wr_count.

## Test plan
- Reset: assert rst_n=0 mid-clock after preloading x5=0x1234 → rs1_id=5 reads 0 immediately; wr_count=0.
- ALU commit: rd=3, we=1, load=0, alu=0xDEADBEEF → same-cycle rs1_id=3 reads 0xDEADBEEF via bypass; after the edge, with we=0, it still reads 0xDEADBEEF; wr_count=1.
- Load select: rd=7, we=1, load=1, dm=0x0000_00FF, alu=0x5555_5555 → wb_data=0xFF; x7=0xFF after the edge.
- x0 protection: rd=0, we=1, alu=0xFFFF_FFFF → wb_we=0; rs1_id=0 and rs2_id=0 read 0; wr_count unchanged.
- Dual-port bypass: x9=1 preloaded; rd=9, we=1, alu=2, rs1_id=rs2_id=9 → both ports read 2 this cycle; with we=0 the next cycle, both read 2.
- Counter wrap: force 0xFFFF_FFFF writes → one more write gives wr_count=0; back-to-back writes on consecutive cycles each increment by 1.
